cpu_fetch_ctrl: RTL and testbench

//   Sequences the instruction-fetch PC and owns the single port of the synchronous instruction RAM.

---
 rtl/cpu_fetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_cpu_fetch_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_fetch_ctrl
//
// Instruction-fetch sequencer. It drives the PC, owns the single port of the
// synchronous instruction RAM, and shares that port with an external program
// loader through a halt/grant handshake.
//
// f_pc/f_valid are registered together with the RAM read, so they describe
// the word appearing on the RAM read data in the same cycle.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   stall          decode cannot accept; hold the current instruction
//   redirect_vld   execute redirects fetch this cycle
//   redirect_pc    redirect target (bits [1:0] ignored)
//   ld_req         loader requests the RAM (level, held for whole session)
//   ld_we          loader write strobe (effective only while ld_gnt=1)
//   ld_addr        loader word address
//   ld_wdata       loader write data
//   ld_gnt         loader currently owns the RAM
//   imem_addr      RAM word address (combinational)
//   imem_re        RAM read enable, data valid the following cycle
//   imem_we        RAM write enable
//   imem_wdata     RAM write data (loader data)
//   f_pc           PC of the instruction on RAM read data this cycle
//   f_valid        RAM read data holds a valid instruction for f_pc
// ---------------------------------------------------------------------------
module cpu_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR         = 32'h0000_0000,
  parameter int          INSTR_MEM_ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            stall,
  input  logic                            redirect_vld,
  input  logic [31:0]                     redirect_pc,
  input  logic                            ld_req,
  input  logic                            ld_we,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]                     ld_wdata,
  output logic                            ld_gnt,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] imem_addr,
  output logic                            imem_re,
  output logic                            imem_we,
  output logic [31:0]                     imem_wdata,
  output logic [31:0]                     f_pc,
  output logic                            f_valid
);

  localparam int W = INSTR_MEM_ADDR_WIDTH;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] f_pc_nxt;
  logic        f_valid_nxt;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'h3;

  // Grant and write enable are decoded from the registered state, so reset
  // forces both low immediately, even in the middle of a loader session.
  assign ld_gnt     = (state == ST_HALT);
  assign imem_wdata = ld_wdata;

  // Next-state and RAM port control. In RUN the priority is
  // loader > redirect > stall > sequential; a redirect arriving together with
  // a loader request is dropped because the loader session restarts from the
  // reset vector anyway.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    f_pc_nxt    = f_pc;
    f_valid_nxt = f_valid;
    imem_addr   = pc[W+1:2];
    imem_re     = 1'b0;
    imem_we     = 1'b0;

    case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
      end

      ST_RUN: begin
        if (ld_req) begin
          state_nxt   = ST_HALT;
          f_valid_nxt = 1'b0;
        end else if (redirect_vld) begin
          // Read the target now so the new path arrives with zero bubbles.
          imem_addr   = redirect_pc[W+1:2];
          imem_re     = 1'b1;
          f_pc_nxt    = redirect_aligned;
          f_valid_nxt = 1'b1;
          pc_nxt      = redirect_aligned + 32'd4;
        end else if (stall) begin
          // Re-read the held word so the RAM output stays stable for decode.
          if (f_valid) begin
            imem_addr = f_pc[W+1:2];
            imem_re   = 1'b1;
          end
        end else begin
          imem_re     = 1'b1;
          f_pc_nxt    = pc;
          f_valid_nxt = 1'b1;
          pc_nxt      = pc + 32'd4;
        end
      end

      ST_HALT: begin
        imem_addr   = ld_addr;
        imem_we     = ld_we;
        f_valid_nxt = 1'b0;
        if (!ld_req) begin
          state_nxt = ST_RUN;
          pc_nxt    = RESET_VECTOR;
        end
      end

      default: begin
        state_nxt   = ST_BOOT;
        f_valid_nxt = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_BOOT;
      pc      <= RESET_VECTOR;
      f_pc    <= 32'h0;
      f_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      f_pc    <= f_pc_nxt;
      f_valid <= f_valid_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_fetch_ctrl
//
// Directed, table-driven bench for cpu_fetch_ctrl with RESET_VECTOR=0x100
// and a 10-bit RAM word address. Each table row is one clock cycle: the
// inputs driven during that cycle and the outputs expected before the next
// rising edge. A hand-written sequence covers reset asserted mid-session.
// ---------------------------------------------------------------------------
module tb_cpu_fetch_ctrl;

  localparam logic [31:0] RV = 32'h100;
  localparam int          W  = 10;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          redirect_vld;
  logic [31:0]   redirect_pc;
  logic          ld_req;
  logic          ld_we;
  logic [W-1:0]  ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt;
  logic [W-1:0]  imem_addr;
  logic          imem_re;
  logic          imem_we;
  logic [31:0]   imem_wdata;
  logic [31:0]   f_pc;
  logic          f_valid;

  int checks_total;
  int checks_passed;

  typedef struct {
    logic         stall;
    logic         rv;
    logic [31:0]  rpc;
    logic         lr;
    logic         lw;
    logic [W-1:0] la;
    logic [31:0]  wd;
    logic         chk_addr;
    logic [W-1:0] exp_addr;
    logic         exp_re;
    logic         exp_we;
    logic         exp_gnt;
    logic         chk_pc;
    logic [31:0]  exp_pc;
    logic         exp_fv;
  } vec_t;

  vec_t vecs[$];

  cpu_fetch_ctrl #(
    .RESET_VECTOR        (RV),
    .INSTR_MEM_ADDR_WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect_vld(redirect_vld),
    .redirect_pc (redirect_pc),
    .ld_req      (ld_req),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_wdata    (ld_wdata),
    .ld_gnt      (ld_gnt),
    .imem_addr   (imem_addr),
    .imem_re     (imem_re),
    .imem_we     (imem_we),
    .imem_wdata  (imem_wdata),
    .f_pc        (f_pc),
    .f_valid     (f_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                              input logic lr, input logic lw, input logic [W-1:0] la,
                              input logic [31:0] wd, input logic ca, input logic [W-1:0] ea,
                              input logic ere, input logic ewe, input logic egnt,
                              input logic cp, input logic [31:0] epc, input logic efv);
    vec_t v;
    v.stall = st; v.rv = rv; v.rpc = rpc; v.lr = lr; v.lw = lw; v.la = la; v.wd = wd;
    v.chk_addr = ca; v.exp_addr = ea; v.exp_re = ere; v.exp_we = ewe; v.exp_gnt = egnt;
    v.chk_pc = cp; v.exp_pc = epc; v.exp_fv = efv;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  // Drive one row at a negedge, compare mid-low-phase, then advance to the
  // next negedge (crossing exactly one rising edge).
  task automatic applyStimulus(input int idx);
    vec_t v;
    string tag;
    v = vecs[idx];
    stall        = v.stall;
    redirect_vld = v.rv;
    redirect_pc  = v.rpc;
    ld_req       = v.lr;
    ld_we        = v.lw;
    ld_addr      = v.la;
    ld_wdata     = v.wd;
    #2;
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, " imem_re"}, {31'b0, imem_re}, {31'b0, v.exp_re});
    checkOutput({tag, " imem_we"}, {31'b0, imem_we}, {31'b0, v.exp_we});
    checkOutput({tag, " ld_gnt"},  {31'b0, ld_gnt},  {31'b0, v.exp_gnt});
    checkOutput({tag, " f_valid"}, {31'b0, f_valid}, {31'b0, v.exp_fv});
    if (v.chk_addr)
      checkOutput({tag, " imem_addr"}, {22'b0, imem_addr}, {22'b0, v.exp_addr});
    if (v.chk_pc)
      checkOutput({tag, " f_pc"}, f_pc, v.exp_pc);
    if (v.exp_we)
      checkOutput({tag, " imem_wdata"}, imem_wdata, v.wd);
    @(negedge clk);
  endtask

  task automatic clearInputs();
    stall = 0; redirect_vld = 0; redirect_pc = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n = 1'b0;
    clearInputs();

    //            st rv rpc            lr lw la wd             ca addr    re we gnt cp pc             fv
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          0,10'h0,   0,0,0,  1,32'h0,        0)); // 0 BOOT
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h40,  1,0,0,  1,32'h0,        0)); // 1 first read
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h41,  1,0,0,  1,32'h100,      1)); // 2
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h42,  1,0,0,  1,32'h104,      1)); // 3
    vecs.push_back(mk(1,0,32'h0,        0,0,0,32'h0,          1,10'h42,  1,0,0,  1,32'h108,      1)); // 4 stall
    vecs.push_back(mk(1,0,32'h0,        0,0,0,32'h0,          1,10'h42,  1,0,0,  1,32'h108,      1)); // 5
    vecs.push_back(mk(1,0,32'h0,        0,0,0,32'h0,          1,10'h42,  1,0,0,  1,32'h108,      1)); // 6
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h43,  1,0,0,  1,32'h108,      1)); // 7 release
    vecs.push_back(mk(0,0,32'h0,        1,0,0,32'h0,          0,10'h0,   0,0,0,  1,32'h10C,      1)); // 8 ld_req
    vecs.push_back(mk(0,0,32'h0,        1,1,5,32'hDEADBEEF,   1,10'h5,   0,1,1,  0,32'h0,        0)); // 9 write
    vecs.push_back(mk(0,0,32'h0,        0,0,5,32'h0,          1,10'h5,   0,0,1,  0,32'h0,        0)); // 10 drop req
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h40,  1,0,0,  0,32'h0,        0)); // 11 restart
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h41,  1,0,0,  1,32'h100,      1)); // 12
    vecs.push_back(mk(1,1,32'h203,      0,0,0,32'h0,          1,10'h80,  1,0,0,  1,32'h104,      1)); // 13 redirect+stall
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h81,  1,0,0,  1,32'h200,      1)); // 14
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h82,  1,0,0,  1,32'h204,      1)); // 15
    vecs.push_back(mk(0,1,32'h300,      1,0,0,32'h0,          0,10'h0,   0,0,0,  1,32'h208,      1)); // 16 ld_req+redirect
    vecs.push_back(mk(0,0,32'h0,        1,0,7,32'h0,          1,10'h7,   0,0,1,  0,32'h0,        0)); // 17 HALT
    vecs.push_back(mk(0,0,32'h0,        0,0,7,32'h0,          1,10'h7,   0,0,1,  0,32'h0,        0)); // 18 drop req
    vecs.push_back(mk(1,0,32'h0,        0,0,0,32'h0,          0,10'h0,   0,0,0,  0,32'h0,        0)); // 19 stall, invalid
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h40,  1,0,0,  0,32'h0,        0)); // 20
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h41,  1,0,0,  1,32'h100,      1)); // 21 not 0x300
    vecs.push_back(mk(0,1,32'hFFFFFFFE, 0,0,0,32'h0,          1,10'h3FF, 1,0,0,  1,32'h104,      1)); // 22 top of space
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h000, 1,0,0,  1,32'hFFFFFFFC, 1)); // 23 wrap
    vecs.push_back(mk(0,1,32'h1004,     0,0,0,32'h0,          1,10'h001, 1,0,0,  1,32'h0,        1)); // 24 alias
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h002, 1,0,0,  1,32'h1004,     1)); // 25
    vecs.push_back(mk(0,0,32'h0,        0,0,0,32'h0,          1,10'h003, 1,0,0,  1,32'h1008,     1)); // 26

    // Reset state while rst_n is held low.
    repeat (2) @(negedge clk);
    #2;
    checkOutput("rst imem_re", {31'b0, imem_re}, 32'd0);
    checkOutput("rst imem_we", {31'b0, imem_we}, 32'd0);
    checkOutput("rst ld_gnt",  {31'b0, ld_gnt},  32'd0);
    checkOutput("rst f_valid", {31'b0, f_valid}, 32'd0);
    checkOutput("rst f_pc",    f_pc,             32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

    // Reset asserted in the middle of a loader write.
    ld_req = 1'b1;
    @(negedge clk);
    ld_we    = 1'b1;
    ld_addr  = 10'd9;
    ld_wdata = 32'h1234_5678;
    #2;
    checkOutput("halt imem_we", {31'b0, imem_we}, 32'd1);
    checkOutput("halt ld_gnt",  {31'b0, ld_gnt},  32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst imem_we", {31'b0, imem_we}, 32'd0);
    checkOutput("midrst ld_gnt",  {31'b0, ld_gnt},  32'd0);
    checkOutput("midrst f_valid", {31'b0, f_valid}, 32'd0);
    checkOutput("midrst imem_re", {31'b0, imem_re}, 32'd0);
    clearInputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(i);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
